// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared op encodings and decoder FSM state type for the CAM write front end
// Contents:
//   CAM_OP_WRITE / CAM_OP_INV  request op encodings
//   cam_dec_state_t            row decoder FSM states (IDLE, FLUSH)
package cam_pkg;

    localparam logic CAM_OP_WRITE = 1'b0;
    localparam logic CAM_OP_INV   = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } cam_dec_state_t;

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - combinational binary to one-hot decoder with range flag
// Parameters:
//   WIDTH     number of one-hot outputs; need not be a power of two
// Ports:
//   bin       in   $clog2(WIDTH)  binary index
//   onehot    out  WIDTH          onehot[bin] set when bin is in range, else all zero
//   in_range  out  1              bin < WIDTH
module onehot_decoder #(
    parameter int WIDTH = 16
) (
    input  logic [$clog2(WIDTH)-1:0] bin,
    output logic [WIDTH-1:0]         onehot,
    output logic                     in_range
);

    always_comb begin
        onehot   = '0;
        in_range = (int'(bin) < WIDTH);
        if (in_range) begin
            onehot[bin] = 1'b1;
        end
    end

endmodule

// File: rtl/cam_row_decoder.sv
// rtl/cam_row_decoder.sv - CAM write-side row decoder with occupancy bits and flush sweep
// Parameters:
//   DEPTH, DATA_WIDTH; AW = $clog2(DEPTH) is derived
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_op, req_addr, req_data     op (0 write, 1 invalidate), row index, row data
//   flush_start / flush_busy       start and status of the full-array clear sweep
//   row_we, row_clr, row_wdata     registered one-hot strobes and write data to the array
//   occ, occ_full                  per-row valid bits and their AND
//   err                            sticky out-of-range flag
// Configuration:
//   CAM_ROW_DECODER_ERR_EN  defined: err tracks out-of-range requests; undefined: err tied 0
module cam_row_decoder
    import cam_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_op,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_data,
    input  logic                     flush_start,
    output logic                     flush_busy,
    output logic [DEPTH-1:0]         row_we,
    output logic [DEPTH-1:0]         row_clr,
    output logic [DATA_WIDTH-1:0]    row_wdata,
    output logic [DEPTH-1:0]         occ,
    output logic                     occ_full,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

    cam_dec_state_t          state_q, state_d;
    logic [AW-1:0]           k_q, k_d;
    logic                    ready_q, ready_d;
    logic [DEPTH-1:0]        we_q, we_d;
    logic [DEPTH-1:0]        clr_q, clr_d;
    logic [DEPTH-1:0]        occ_q, occ_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [DEPTH-1:0]        req_oh, flush_oh;
    logic                    req_in_range, flush_in_range;
    logic                    accept;

    onehot_decoder #(.WIDTH(DEPTH)) u_req_dec (
        .bin      (req_addr),
        .onehot   (req_oh),
        .in_range (req_in_range)
    );

    // Decodes the row the sweep will clear on the next cycle, so the
    // flush strobe is registered just like the request strobes.
    onehot_decoder #(.WIDTH(DEPTH)) u_flush_dec (
        .bin      (k_d),
        .onehot   (flush_oh),
        .in_range (flush_in_range)
    );

    assign accept = req_valid & ready_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        we_d    = '0;
        clr_d   = '0;
        occ_d   = occ_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (flush_start) begin
                    state_d = FLUSH;
                    k_d     = '0;
                end
            end
            FLUSH: begin
                if (k_q == LAST_ROW) begin
                    state_d = IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase

        if (accept && req_in_range) begin
            if (req_op == CAM_OP_WRITE) begin
                we_d    = req_oh;
                occ_d   = occ_q | req_oh;
                wdata_d = req_data;
            end else begin
                clr_d = req_oh;
                occ_d = occ_q & ~req_oh;
            end
        end

        // The sweep clear is applied last so it wins over a same-cycle write.
        // It replaces a same-cycle invalidate strobe to keep row_clr one-hot;
        // that row is cleared again by the sweep anyway.
        if (state_d == FLUSH && flush_in_range) begin
            clr_d = flush_oh;
            occ_d = occ_d & ~flush_oh;
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            ready_q <= 1'b0;
            we_q    <= '0;
            clr_q   <= '0;
            occ_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            clr_q   <= clr_d;
            occ_q   <= occ_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef CAM_ROW_DECODER_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept && !req_in_range) begin
            err_d = 1'b1;
        end
        if (state_q == FLUSH && k_q == LAST_ROW) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign req_ready  = ready_q;
    assign flush_busy = (state_q == FLUSH);
    assign row_we     = we_q;
    assign row_clr    = clr_q;
    assign row_wdata  = wdata_q;
    assign occ        = occ_q;
    assign occ_full   = &occ_q;

endmodule

// File: tb/tb_cam_row_decoder.sv
// tb/tb_cam_row_decoder.sv - self-checking bench for cam_row_decoder (DEPTH 16 and DEPTH 12 instances)
module tb_cam_row_decoder;

`ifdef CAM_ROW_DECODER_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    int          tests_run    = 0;
    int          tests_failed = 0;

    // DEPTH=16 instance
    logic        req_valid, req_op, flush_start;
    logic [3:0]  req_addr;
    logic [31:0] req_data;
    logic        req_ready, flush_busy, occ_full, err;
    logic [15:0] row_we, row_clr, occ;
    logic [31:0] row_wdata;

    // DEPTH=12 instance
    logic        v12, op12, fs12;
    logic [3:0]  a12;
    logic [31:0] d12;
    logic        rdy12, busy12, full12, err12;
    logic [11:0] we12, clr12, occ12;
    logic [31:0] wd12;

    typedef struct packed {
        logic [15:0] we;
        logic [15:0] clr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    cam_row_decoder #(.DEPTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .flush_start(flush_start), .flush_busy(flush_busy),
        .row_we(row_we), .row_clr(row_clr), .row_wdata(row_wdata),
        .occ(occ), .occ_full(occ_full), .err(err)
    );

    cam_row_decoder #(.DEPTH(12), .DATA_WIDTH(32)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v12), .req_ready(rdy12), .req_op(op12),
        .req_addr(a12), .req_data(d12),
        .flush_start(fs12), .flush_busy(busy12),
        .row_we(we12), .row_clr(clr12), .row_wdata(wd12),
        .occ(occ12), .occ_full(full12), .err(err12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests_run++;
        if ({req_ready, flush_busy, row_we, row_clr, row_wdata, occ, occ_full, err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b we=%h clr=%h wd=%h occ=%h full=%b err=%b, want all 0",
                     req_ready, flush_busy, row_we, row_clr, row_wdata, occ, occ_full, err);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (req_ready !== 1'b1 || flush_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: rdy=%b busy=%b, want rdy=1 busy=0", req_ready, flush_busy);
        end
    endtask

    task automatic test_write_single();
        req_valid = 1'b1; req_op = 1'b0; req_addr = 4'd5; req_data = 32'hDEADBEEF;
        sb.push_back('{we: 16'h0020, clr: 16'h0000, wdata: 32'hDEADBEEF});
        tick();
        req_valid = 1'b0;
        e = sb.pop_front();
        tests_run++;
        if (row_we !== e.we || row_clr !== e.clr || row_wdata !== e.wdata) begin
            tests_failed++;
            $display("FAIL write_single: we=%h clr=%h wd=%h, want we=%h clr=%h wd=%h",
                     row_we, row_clr, row_wdata, e.we, e.clr, e.wdata);
        end
        tests_run++;
        if (occ !== 16'h0020) begin
            tests_failed++;
            $display("FAIL write_single_occ: occ=%h, want 0020", occ);
        end
        tick();
        tests_run++;
        if (row_we !== 16'h0000) begin
            tests_failed++;
            $display("FAIL write_single_idle: we=%h, want 0000", row_we);
        end
    endtask

    task automatic test_stream_writes();
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_op = 1'b0; req_addr = 4'(i); req_data = 32'h1000_0000 + i;
            sb.push_back('{we: 16'(1) << i, clr: 16'h0000, wdata: 32'h1000_0000 + i});
            tick();
            e = sb.pop_front();
            tests_run++;
            if (row_we !== e.we || row_clr !== e.clr || row_wdata !== e.wdata) begin
                tests_failed++;
                $display("FAIL stream_row%0d: we=%h clr=%h wd=%h, want we=%h clr=%h wd=%h",
                         i, row_we, row_clr, row_wdata, e.we, e.clr, e.wdata);
            end
        end
        req_valid = 1'b0;
        tick();
        tests_run++;
        if (occ_full !== 1'b1 || occ !== 16'hFFFF || row_we !== 16'h0000) begin
            tests_failed++;
            $display("FAIL stream_full: full=%b occ=%h we=%h, want full=1 occ=ffff we=0000", occ_full, occ, row_we);
        end
    endtask

    task automatic test_invalidate();
        req_valid = 1'b1; req_op = 1'b1; req_addr = 4'd3; req_data = 32'h0;
        sb.push_back('{we: 16'h0000, clr: 16'h0008, wdata: 32'h1000_000F});
        tick();
        req_valid = 1'b0;
        e = sb.pop_front();
        tests_run++;
        if (row_clr !== e.clr || row_we !== e.we || occ !== 16'hFFF7 || occ_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL invalidate: clr=%h we=%h occ=%h full=%b, want clr=%h we=%h occ=fff7 full=0",
                     row_clr, row_we, occ, occ_full, e.clr, e.we);
        end
        tick();
        tests_run++;
        if (row_clr !== 16'h0000) begin
            tests_failed++;
            $display("FAIL invalidate_width: clr=%h, want 0000", row_clr);
        end
    endtask

    task automatic test_flush_with_write();
        flush_start = 1'b1;
        req_valid = 1'b1; req_op = 1'b0; req_addr = 4'd0; req_data = 32'hCAFE0000;
        sb.push_back('{we: 16'h0001, clr: 16'h0001, wdata: 32'hCAFE0000});
        for (int k = 1; k < 16; k++) begin
            sb.push_back('{we: 16'h0000, clr: 16'(1) << k, wdata: 32'hCAFE0000});
        end
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (occ[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_write_row0: occ[0]=%b, want 0", occ[0]);
        end
        for (int k = 0; k < 16; k++) begin
            e = sb.pop_front();
            tests_run++;
            if (row_we !== e.we || row_clr !== e.clr || row_wdata !== e.wdata
                || flush_busy !== 1'b1 || req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_row%0d: we=%h clr=%h wd=%h busy=%b rdy=%b, want we=%h clr=%h wd=%h busy=1 rdy=0",
                         k, row_we, row_clr, row_wdata, flush_busy, req_ready, e.we, e.clr, e.wdata);
            end
            if (k == 14) flush_start = 1'b0;
            tick();
        end
        tests_run++;
        if (flush_busy !== 1'b0 || req_ready !== 1'b1 || occ !== 16'h0000 || row_clr !== 16'h0000) begin
            tests_failed++;
            $display("FAIL flush_end: busy=%b rdy=%b occ=%h clr=%h, want busy=0 rdy=1 occ=0000 clr=0000",
                     flush_busy, req_ready, occ, row_clr);
        end
    endtask

    task automatic test_out_of_range();
        v12 = 1'b1; op12 = 1'b0; a12 = 4'd2; d12 = 32'h0000_0002;
        tick();
        v12 = 1'b1; op12 = 1'b0; a12 = 4'd13; d12 = 32'h0000_000D;
        tick();
        v12 = 1'b0;
        tests_run++;
        if (we12 !== 12'h000 || clr12 !== 12'h000 || occ12 !== 12'h004) begin
            tests_failed++;
            $display("FAIL oor_nostrobe: we=%h clr=%h occ=%h, want we=000 clr=000 occ=004", we12, clr12, occ12);
        end
        tests_run++;
        if (err12 !== ERR_EN) begin
            tests_failed++;
            $display("FAIL oor_err: err=%b, want %b", err12, ERR_EN);
        end
        fs12 = 1'b1;
        tick();
        fs12 = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        tests_run++;
        if (err12 !== 1'b0 || occ12 !== 12'h000 || busy12 !== 1'b0 || rdy12 !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_flush_clear: err=%b occ=%h busy=%b rdy=%b, want err=0 occ=000 busy=0 rdy=1",
                     err12, occ12, busy12, rdy12);
        end
    endtask

    task automatic test_reset_mid_flush();
        req_valid = 1'b1; req_op = 1'b0; req_addr = 4'd12; req_data = 32'h0000_1212;
        tick();
        req_valid = 1'b0;
        flush_start = 1'b1;
        tick();
        flush_start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        tests_run++;
        if (row_clr !== 16'h0080 || flush_busy !== 1'b1 || occ !== 16'h1000) begin
            tests_failed++;
            $display("FAIL midflush_row7: clr=%h busy=%b occ=%h, want clr=0080 busy=1 occ=1000", row_clr, flush_busy, occ);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, flush_busy, row_we, row_clr, row_wdata, occ, occ_full, err} !== '0) begin
            tests_failed++;
            $display("FAIL midflush_async_reset: rdy=%b busy=%b we=%h clr=%h wd=%h occ=%h full=%b err=%b, want all 0",
                     req_ready, flush_busy, row_we, row_clr, row_wdata, occ, occ_full, err);
        end
        #5;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (req_ready !== 1'b1 || flush_busy !== 1'b0 || row_clr !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midflush_release: rdy=%b busy=%b clr=%h, want rdy=1 busy=0 clr=0000", req_ready, flush_busy, row_clr);
        end
        req_valid = 1'b1; req_op = 1'b0; req_addr = 4'd9; req_data = 32'h0000_0909;
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (row_we !== 16'h0200 || occ !== 16'h0200) begin
            tests_failed++;
            $display("FAIL midflush_resume: we=%h occ=%h, want we=0200 occ=0200", row_we, occ);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_data = '0; flush_start = 1'b0;
        v12 = 1'b0; op12 = 1'b0; a12 = '0; d12 = '0; fs12 = 1'b0;
        test_reset();
        test_write_single();
        test_stream_writes();
        test_invalidate();
        test_flush_with_write();
        test_out_of_range();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
